// File: rtl/phys_regfile_pkg.sv
// Shared definitions for the physical register file: the preg-index width helper,
// the hard-wired zero register, and the default preg index type.
package regfile_pkg;

  function automatic int preg_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ZERO_PREG     = 0;
  localparam int DEF_NUM_PREGS = 64;
  localparam int PREG_W        = preg_width(DEF_NUM_PREGS);

  typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/phys_regfile_if.sv
// Back-end bus into the physical register file: rename alloc, write-back and read ports.
// Reads are combinational and writes land on the next rising clock. There is no valid/ready pairing: every input is sampled each cycle and every output is always valid.
interface phys_regfile_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_PREGS = 64,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2
);
  localparam int PW = regfile_pkg::preg_width(NUM_PREGS);

  logic                    alloc_en;
  logic [PW-1:0]           alloc_preg;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*PW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [NUM_RD*PW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_ready;
  logic                    wr_conflict;

  modport master (
    output alloc_en, alloc_preg, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, rd_ready, wr_conflict
  );

  modport slave (
    input  alloc_en, alloc_preg, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, rd_ready, wr_conflict
  );
endinterface

// File: rtl/phys_regfile_read_port.sv
// One read port: stored-state lookup with optional same-cycle forwarding from the
// write-back ports, highest-numbered matching port taking priority.
module prf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PW     = 6,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic [PW-1:0]           rd_addr_i,
  input  logic [NUM_WR-1:0]       wr_en_i,
  input  logic [NUM_WR*PW-1:0]    wr_addr_i,
  input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
  input  logic [WIDTH-1:0]        st_data_i,
  input  logic                    st_ready_i,
  output logic [WIDTH-1:0]        rd_data_o,
  output logic                    rd_ready_o
);

  always_comb begin
    rd_data_o  = st_data_i;
    rd_ready_o = st_ready_i;
    if (BYPASS != 0) begin
      // Ascending scan so the highest matching write port ends up selected.
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*PW +: PW] == rd_addr_i) &&
            (rd_addr_i != PW'(ZERO_PREG))) begin
          rd_data_o  = wr_data_i[k*WIDTH +: WIDTH];
          rd_ready_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phys_regfile.sv
// Physical register file with per-preg ready scoreboard, NUM_WR write-back ports,
// NUM_RD combinational read ports and a sticky write-collision flag.
module phys_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_PREGS = 64,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int BYPASS    = 1
) (
  input logic           clk,
  input logic           reset,
  phys_regfile_if.slave bus
);
  localparam int PW = preg_width(NUM_PREGS);

  logic [WIDTH-1:0]     data_q [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready_q, ready_d;
  logic                 conflict_q, conflict_d;

  always_comb begin
    ready_d    = ready_q;
    conflict_d = conflict_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (bus.wr_en[k] && (bus.wr_addr[k*PW +: PW] != PW'(ZERO_PREG)))
        ready_d[bus.wr_addr[k*PW +: PW]] = 1'b1;
    end
    // Alloc is applied after write-back: the newly renamed producer owns the preg.
    if (bus.alloc_en && (bus.alloc_preg != PW'(ZERO_PREG)))
      ready_d[bus.alloc_preg] = 1'b0;
    ready_d[ZERO_PREG] = 1'b1;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] &&
            (bus.wr_addr[i*PW +: PW] == bus.wr_addr[j*PW +: PW]) &&
            (bus.wr_addr[i*PW +: PW] != PW'(ZERO_PREG)))
          conflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) data_q[i] <= '0;
      ready_q    <= '1;
      conflict_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      conflict_q <= conflict_d;
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && (bus.wr_addr[k*PW +: PW] != PW'(ZERO_PREG)))
          data_q[bus.wr_addr[k*PW +: PW]] <= bus.wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.wr_conflict = conflict_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [PW-1:0]    addr;
    logic [WIDTH-1:0] port_data;
    logic             port_ready;

    assign addr = bus.rd_addr[p*PW +: PW];

    prf_read_port #(
      .WIDTH (WIDTH),
      .PW    (PW),
      .NUM_WR(NUM_WR),
      .BYPASS(BYPASS)
    ) u_port (
      .rd_addr_i (addr),
      .wr_en_i   (bus.wr_en),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .st_data_i (data_q[addr]),
      .st_ready_i(ready_q[addr]),
      .rd_data_o (port_data),
      .rd_ready_o(port_ready)
    );

    assign bus.rd_data[p*WIDTH +: WIDTH] = port_data;
    assign bus.rd_ready[p]               = port_ready;
  end

endmodule

// File: tb/tb_phys_regfile.sv
// Bench for phys_regfile: a BYPASS=1 and a BYPASS=0 instance share one stimulus stream
// and are checked against a preg-array model, a directed vector table and random traffic.
module tb_phys_regfile;
  localparam int W  = 32;
  localparam int NP = 64;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              alloc_en;
  logic [PW-1:0]     alloc_preg;
  logic [NW-1:0]     wr_en;
  logic [NW*PW-1:0]  wr_addr;
  logic [NW*W-1:0]   wr_data;
  logic [NR*PW-1:0]  rd_addr;

  phys_regfile_if #(.WIDTH(W), .NUM_PREGS(NP), .NUM_RD(NR), .NUM_WR(NW)) if_b ();
  phys_regfile_if #(.WIDTH(W), .NUM_PREGS(NP), .NUM_RD(NR), .NUM_WR(NW)) if_n ();

  assign if_b.alloc_en   = alloc_en;
  assign if_b.alloc_preg = alloc_preg;
  assign if_b.wr_en      = wr_en;
  assign if_b.wr_addr    = wr_addr;
  assign if_b.wr_data    = wr_data;
  assign if_b.rd_addr    = rd_addr;
  assign if_n.alloc_en   = alloc_en;
  assign if_n.alloc_preg = alloc_preg;
  assign if_n.wr_en      = wr_en;
  assign if_n.wr_addr    = wr_addr;
  assign if_n.wr_data    = wr_data;
  assign if_n.rd_addr    = rd_addr;

  phys_regfile #(.WIDTH(W), .NUM_PREGS(NP), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));
  phys_regfile #(.WIDTH(W), .NUM_PREGS(NP), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .bus(if_n.slave));

  // Reference model: plain arrays updated by the rules of the register file.
  logic [W-1:0] m_data [NP];
  bit           m_ready[NP];
  bit           m_conf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          alloc_en;
    int          alloc_preg;
    int          wr_en;
    int          wa0, wa1;
    logic [31:0] wd0, wd1;
    int          ra;
    logic [31:0] eb_d;
    int          eb_r;
    logic [31:0] en_d;
    int          en_r;
    int          e_conf;
  } vec_t;

  vec_t vecs[12];

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      m_data[i]  = '0;
      m_ready[i] = 1'b1;
    end
    m_conf = 1'b0;
  endfunction

  function automatic void model_clock();
    int a [NW];
    for (int k = 0; k < NW; k++) a[k] = int'(wr_addr[k*PW +: PW]);
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NW; i++)
      for (int j = i + 1; j < NW; j++)
        if (wr_en[i] && wr_en[j] && a[i] == a[j] && a[i] != 0) m_conf = 1'b1;
    for (int k = 0; k < NW; k++)
      if (wr_en[k] && a[k] != 0) begin
        m_data[a[k]]  = wr_data[k*W +: W];
        m_ready[a[k]] = 1'b1;
      end
    if (alloc_en && alloc_preg != 0) m_ready[alloc_preg] = 1'b0;
  endfunction

  function automatic void model_read(input bit byp, input int addr,
                                     output logic [W-1:0] d, output bit r);
    d = m_data[addr];
    r = m_ready[addr];
    if (byp && addr != 0)
      for (int k = 0; k < NW; k++)
        if (wr_en[k] && int'(wr_addr[k*PW +: PW]) == addr) begin
          d = wr_data[k*W +: W];
          r = 1'b1;
        end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] d;
    bit r;
    for (int p = 0; p < NR; p++) begin
      model_read(1'b1, int'(rd_addr[p*PW +: PW]), d, r);
      check($sformatf("byp_data_p%0d", p), if_b.rd_data[p*W +: W], d);
      check($sformatf("byp_ready_p%0d", p), {31'b0, if_b.rd_ready[p]}, {31'b0, r});
      model_read(1'b0, int'(rd_addr[p*PW +: PW]), d, r);
      check($sformatf("nob_data_p%0d", p), if_n.rd_data[p*W +: W], d);
      check($sformatf("nob_ready_p%0d", p), {31'b0, if_n.rd_ready[p]}, {31'b0, r});
    end
    check("byp_conflict", {31'b0, if_b.wr_conflict}, {31'b0, m_conf});
    check("nob_conflict", {31'b0, if_n.wr_conflict}, {31'b0, m_conf});
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    alloc_en   = 1'b0;
    alloc_preg = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
  endtask

  task automatic read_all(input int a);
    for (int p = 0; p < NR; p++) rd_addr[p*PW +: PW] = PW'(a);
  endtask

  initial begin
    reset   = 1'b1;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    //            al pr we wa0 wa1 wd0       wd1       ra  eb_d      eb_r en_d      en_r conf
    vecs[0]  = '{0, 0, 0, 0,  0, 0,        0,        5,  0,        1,   0,        1,   0};
    vecs[1]  = '{0, 0, 1, 0,  0, 32'hDEAD, 0,        0,  0,        1,   0,        1,   0};
    vecs[2]  = '{1, 7, 0, 0,  0, 0,        0,        7,  0,        1,   0,        1,   0};
    vecs[3]  = '{0, 0, 0, 0,  0, 0,        0,        7,  0,        0,   0,        0,   0};
    vecs[4]  = '{0, 0, 2, 0,  7, 0,        32'h1234, 7,  32'h1234, 1,   0,        0,   0};
    vecs[5]  = '{0, 0, 0, 0,  0, 0,        0,        7,  32'h1234, 1,   32'h1234, 1,   0};
    vecs[6]  = '{0, 0, 3, 9,  9, 32'hAAAA, 32'hBBBB, 9,  32'hBBBB, 1,   0,        1,   0};
    vecs[7]  = '{0, 0, 0, 0,  0, 0,        0,        9,  32'hBBBB, 1,   32'hBBBB, 1,   1};
    vecs[8]  = '{1, 12, 1, 12, 0, 32'h55,  0,        12, 32'h55,   1,   0,        1,   1};
    vecs[9]  = '{0, 0, 0, 0,  0, 0,        0,        12, 32'h55,   0,   32'h55,   0,   1};
    vecs[10] = '{0, 0, 1, 12, 0, 32'h66,   0,        12, 32'h66,   1,   32'h55,   0,   1};
    vecs[11] = '{0, 0, 0, 0,  0, 0,        0,        12, 32'h66,   1,   32'h66,   1,   1};

    for (int i = 0; i < 12; i++) begin
      alloc_en   = vecs[i].alloc_en;
      alloc_preg = PW'(vecs[i].alloc_preg);
      wr_en      = NW'(vecs[i].wr_en);
      wr_addr    = {PW'(vecs[i].wa1), PW'(vecs[i].wa0)};
      wr_data    = {vecs[i].wd1, vecs[i].wd0};
      read_all(vecs[i].ra);
      #1;
      check($sformatf("vec%0d_byp_data", i), if_b.rd_data[W-1:0], vecs[i].eb_d);
      check($sformatf("vec%0d_byp_ready", i), {31'b0, if_b.rd_ready[0]}, vecs[i].eb_r);
      check($sformatf("vec%0d_nob_data", i), if_n.rd_data[W-1:0], vecs[i].en_d);
      check($sformatf("vec%0d_nob_ready", i), {31'b0, if_n.rd_ready[0]}, vecs[i].en_r);
      check($sformatf("vec%0d_conflict", i), {31'b0, if_b.wr_conflict}, vecs[i].e_conf);
      cycle();
    end

    // Reset must win over a same-cycle alloc and colliding writes.
    alloc_en   = 1'b1;
    alloc_preg = PW'(3);
    wr_en      = '1;
    wr_addr    = {PW'(3), PW'(3)};
    wr_data    = {32'hCAFE, 32'hBEEF};
    reset      = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    for (int g = 0; g < NP; g += NR) begin
      for (int p = 0; p < NR; p++) rd_addr[p*PW +: PW] = PW'(g + p);
      #1;
      for (int p = 0; p < NR; p++) begin
        check($sformatf("rst_byp_data_%0d", g + p), if_b.rd_data[p*W +: W], 32'h0);
        check($sformatf("rst_byp_ready_%0d", g + p), {31'b0, if_b.rd_ready[p]}, 32'h1);
        check($sformatf("rst_nob_ready_%0d", g + p), {31'b0, if_n.rd_ready[p]}, 32'h1);
      end
      check("rst_conflict", {31'b0, if_b.wr_conflict}, 32'h0);
    end
    cycle();

    // Random traffic over a narrow preg range so collisions and bypass hits are frequent.
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_preg = PW'($urandom_range(0, 15));
      wr_en      = NW'($urandom_range(0, 3));
      for (int k = 0; k < NW; k++) begin
        wr_addr[k*PW +: PW] = PW'($urandom_range(0, 15));
        wr_data[k*W +: W]   = $urandom;
      end
      for (int p = 0; p < NR; p++) rd_addr[p*PW +: PW] = PW'($urandom_range(0, 15));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
